mcs4_timing_gen: RTL

MCS-4 instruction-cycle timing generator. It consumes the two-phase clock (PHI1/PHI2, active-low, 7 clk_i periods per phase cycle) and sequences the eight subcycles of a 4004 instruction cycle: A1 A2 A3 M1 M2 X1 X2 X3. In master (CPU) role it drives SYNC; in slave (ROM/RAM) role it locks its subcycle counter to an external SYNC. It sits directly downstream of the two-phase clock generator and feeds the bus/decoder stages.

---
 rtl/mcs4_pkg.sv | 26 ++
 rtl/mcs4_phase_edge.sv | 63 ++++++
 rtl/mcs4_timing_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mcs4_pkg.sv
// mcs4_pkg: shared definitions for the MCS-4 instruction-cycle timing
// generator. It holds the subcycle codes (A1..X3), the subcycle width and
// the number of subcycles per instruction cycle.
// The optional phase checker is selected with the macro MCS4_TIMING_CHECK_EN.
package mcs4_pkg;

  localparam int SC_W                 = 3;
  localparam int SUBCYCLES_PER_ICYCLE = 8;

  typedef enum logic [SC_W-1:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  // Successor subcycle. The 3-bit add wraps X3 back to A1.
  function automatic subcycle_e sc_next(input subcycle_e sc);
    return subcycle_e'(sc + 3'd1);
  endfunction

endpackage

// File: rtl/mcs4_phase_edge.sv
// mcs4_phase_edge: one flop of edge history on the two-phase clock.
// Optional checker macro: MCS4_TIMING_CHECK_EN.
//   clk_i, rst_i   : design clock and synchronous active-high reset
//   phi1_i, phi2_i : active-low clock phases
//   adv_o          : end of a PHI2 pulse; this is the subcycle boundary
//   overlap_err_o  : (checker only) both phases low in the same sample
//   miss_p2_err_o  : (checker only) second PHI1 fall with no adv in between
module mcs4_phase_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic phi1_i,
  input  logic phi2_i,
`ifdef MCS4_TIMING_CHECK_EN
  output logic overlap_err_o,
  output logic miss_p2_err_o,
`endif
  output logic adv_o
);

  logic p1_q, p1_d;
  logic p2_q, p2_d;
  logic p1_fall;

  always_comb begin
    p1_d    = phi1_i;
    p2_d    = phi2_i;
    adv_o   = phi2_i & ~p2_q;
    p1_fall = ~phi1_i & p1_q;
  end

`ifdef MCS4_TIMING_CHECK_EN
  // A PHI1 fall has been seen since the last adv.
  logic pend_q, pend_d;

  always_comb begin
    pend_d        = pend_q;
    if (adv_o)        pend_d = 1'b0;
    else if (p1_fall) pend_d = 1'b1;
    overlap_err_o = ~phi1_i & ~phi2_i;
    miss_p2_err_o = p1_fall & pend_q & ~adv_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end
`else
  logic unused_p1_fall;
  assign unused_p1_fall = p1_fall;
`endif

  // Idle level of both phases is high, so history resets to 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p1_q <= 1'b1;
      p2_q <= 1'b1;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
    end
  end

endmodule

// File: rtl/mcs4_timing_gen.sv
// mcs4_timing_gen: sequences the eight subcycles of a 4004 instruction
// cycle from the two-phase clock. MASTER=1 generates SYNC; MASTER=0 locks
// to an external SYNC. Optional phase checker macro: MCS4_TIMING_CHECK_EN.
//   clk_i, rst_i    : design clock, synchronous active-high reset
//   PHI1_i, PHI2_i  : active-low phases
//   SYNC_i          : external SYNC, active-low (slave only)
//   SYNC_o          : low for the whole of X3
//   subcycle_o      : current subcycle code
//   sc_strobe_o     : one-clk pulse on every subcycle boundary
//   icycle_start_o  : one-clk pulse when entering A1
//   locked_o        : slave locked to SYNC_i (always 1 as master)
//   err_o           : sticky timing error (checker build only)
//
// code | subcycle
//   0  | A1  address low nibble
//   1  | A2  address mid nibble
//   2  | A3  address high nibble
//   3  | M1  opcode high nibble
//   4  | M2  opcode low nibble
//   5  | X1  execute 1
//   6  | X2  execute 2
//   7  | X3  execute 3, SYNC low; reset and unlocked-slave state
module mcs4_timing_gen
  import mcs4_pkg::*;
#(
  parameter bit MASTER = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            PHI1_i,
  input  logic            PHI2_i,
  input  logic            SYNC_i,
  output logic            SYNC_o,
  output logic [SC_W-1:0] subcycle_o,
  output logic            sc_strobe_o,
  output logic            icycle_start_o,
  output logic            locked_o,
  output logic            err_o
);

  logic      adv;
  subcycle_e subcycle_q, subcycle_d;
  logic      sync_q, sync_d;
  logic      sc_strobe_q, sc_strobe_d;
  logic      icycle_start_q, icycle_start_d;
  logic      locked_q, locked_d;
  logic      err_q, err_d;
  logic      misalign;

`ifdef MCS4_TIMING_CHECK_EN
  logic overlap_err, miss_p2_err;
`endif

  mcs4_phase_edge u_phase_edge (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .phi1_i        (PHI1_i),
    .phi2_i        (PHI2_i),
`ifdef MCS4_TIMING_CHECK_EN
    .overlap_err_o (overlap_err),
    .miss_p2_err_o (miss_p2_err),
`endif
    .adv_o         (adv)
  );

  always_comb begin
    subcycle_d = subcycle_q;
    locked_d   = locked_q;
    misalign   = 1'b0;
    if (adv) begin
      if (MASTER) begin
        subcycle_d = sc_next(subcycle_q);
      end else if (!SYNC_i) begin
        // SYNC marks the X3->A1 boundary; any other position is a slip.
        subcycle_d = SC_A1;
        locked_d   = 1'b1;
        misalign   = locked_q && (subcycle_q != SC_X3);
      end else if (locked_q) begin
        subcycle_d = sc_next(subcycle_q);
      end else begin
        subcycle_d = SC_X3;
      end
    end
    sc_strobe_d    = adv;
    icycle_start_d = adv && (subcycle_d == SC_A1);
    sync_d         = (subcycle_d != SC_X3);
  end

`ifdef MCS4_TIMING_CHECK_EN
  always_comb err_d = err_q | overlap_err | miss_p2_err | misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  always_comb err_d = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      subcycle_q     <= SC_X3;
      sync_q         <= 1'b0;
      sc_strobe_q    <= 1'b0;
      icycle_start_q <= 1'b0;
      locked_q       <= MASTER;
      err_q          <= 1'b0;
    end else begin
      subcycle_q     <= subcycle_d;
      sync_q         <= sync_d;
      sc_strobe_q    <= sc_strobe_d;
      icycle_start_q <= icycle_start_d;
      locked_q       <= locked_d;
      err_q          <= err_d;
    end
  end

  assign subcycle_o     = subcycle_q;
  assign SYNC_o         = sync_q;
  assign sc_strobe_o    = sc_strobe_q;
  assign icycle_start_o = icycle_start_q;
  assign locked_o       = locked_q;
  assign err_o          = err_q;

endmodule
